// File: rtl/riscv_pkg.sv
// Shared fetch-redirect types: FSM encoding, redirect source select, defaults.
// Imported by the priority mux and the redirect controller.
package riscv_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam logic [7:0] DRAIN_MAX_DEF = 8'd255;

  typedef enum logic [2:0] {
    SRC_NONE  = 3'd0,
    SRC_CSR   = 3'd1,
    SRC_EX    = 3'd2,
    SRC_PEND  = 3'd3,
    SRC_FENCE = 3'd4,
    SRC_JUMP  = 3'd5
  } src_e;

endpackage

// File: rtl/redirect_prio_mux.sv
// Combinational redirect source priority select and target compute.
// Order: csr > ex > pending > fence flush > jump.
module redirect_prio_mux
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            csr_v_i,
  input  logic [XLEN-1:0] csr_addr_i,
  input  logic            ex_v_i,
  input  logic [XLEN-1:0] ex_addr_i,
  input  logic            mispredict_i,
  input  logic [XLEN-1:0] saved_pc_i,
  input  logic            pend_v_i,
  input  logic [XLEN-1:0] pend_addr_i,
  input  logic            fence_v_i,
  input  logic [XLEN-1:0] fence_addr_i,
  input  logic            jump_v_i,
  input  logic [XLEN-1:0] jump_addr_i,
  output src_e            sel_o,
  output logic [XLEN-1:0] addr_o
);

  logic [XLEN-1:0] ex_tgt;

  // A mispredicted taken branch falls through to the next sequential PC.
  assign ex_tgt = mispredict_i ? saved_pc_i + XLEN'(4) : ex_addr_i;

  always_comb begin
    sel_o  = SRC_NONE;
    addr_o = '0;
    priority case (1'b1)
      csr_v_i: begin
        sel_o  = SRC_CSR;
        addr_o = csr_addr_i;
      end
      ex_v_i: begin
        sel_o  = SRC_EX;
        addr_o = ex_tgt;
      end
      pend_v_i: begin
        sel_o  = SRC_PEND;
        addr_o = pend_addr_i;
      end
      fence_v_i: begin
        sel_o  = SRC_FENCE;
        addr_o = fence_addr_i;
      end
      jump_v_i: begin
        sel_o  = SRC_JUMP;
        addr_o = jump_addr_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Next-PC redirect arbiter with a one-entry pending slot and FENCE.I
// drain/flush sequencer.
module fetch_redirect_ctrl
  import riscv_pkg::*;
#(
  parameter int         XLEN      = 32,
  parameter logic [7:0] DRAIN_MAX = DRAIN_MAX_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_redir_valid,
  input  logic [XLEN-1:0] csr_redir_addr,
  input  logic            ex_redir_valid,
  input  logic [XLEN-1:0] ex_redir_addr,
  input  logic            mispredict,
  input  logic [XLEN-1:0] saved_pc,
  input  logic            jump_valid,
  input  logic [XLEN-1:0] jump_target,
  input  logic            fetch_stall,
  input  logic            fence_req,
  input  logic [XLEN-1:0] fence_pc,
  input  logic            pipe_empty,
  output logic            redir_valid,
  output logic [XLEN-1:0] redir_addr,
  input  logic            redir_ready,
  output logic            pc_hold,
  output logic            flush_if,
  output logic            flush_id,
  output logic            fence_busy,
  output logic            fence_timeout
);

  logic [1:0]      st_q, st_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            pend_v_q, pend_v_d;
  logic            pend_full_q, pend_full_d;
  logic [XLEN-1:0] pend_a_q, pend_a_d;
  logic [XLEN-1:0] fen_a_q, fen_a_d;

  logic            busy, hi, jump_ok, vld, acc, tmo, full;
  src_e            sel;
  logic [XLEN-1:0] addr;

  assign busy    = st_q != ST_IDLE;
  assign hi      = csr_redir_valid | ex_redir_valid;
  assign jump_ok = jump_valid & ~fetch_stall & ~busy;

  redirect_prio_mux #(.XLEN(XLEN)) u_mux (
    .csr_v_i      (csr_redir_valid),
    .csr_addr_i   (csr_redir_addr),
    .ex_v_i       (ex_redir_valid),
    .ex_addr_i    (ex_redir_addr),
    .mispredict_i (mispredict),
    .saved_pc_i   (saved_pc),
    .pend_v_i     (pend_v_q),
    .pend_addr_i  (pend_a_q),
    .fence_v_i    (st_q == ST_FLUSH),
    .fence_addr_i (fen_a_q),
    .jump_v_i     (jump_ok),
    .jump_addr_i  (jump_target),
    .sel_o        (sel),
    .addr_o       (addr)
  );

  assign vld  = sel != SRC_NONE;
  assign acc  = vld & redir_ready;
  assign full = (sel == SRC_CSR) | (sel == SRC_EX) | (sel == SRC_FENCE)
              | ((sel == SRC_PEND) & pend_full_q);

  // Outputs are forced quiet while reset is held.
  assign redir_valid   = vld & ~rst;
  assign redir_addr    = rst ? '0 : addr;
  assign flush_if      = acc & ~rst;
  assign flush_id      = acc & full & ~rst;
  assign pc_hold       = (st_q == ST_DRAIN) & ~rst;
  assign fence_busy    = busy & ~rst;
  assign fence_timeout = tmo & ~rst;

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    fen_a_d = fen_a_q;
    tmo     = 1'b0;
    case (st_q)
      ST_IDLE: begin
        if (fence_req && !hi) begin
          st_d    = ST_DRAIN;
          cnt_d   = 8'd0;
          fen_a_d = fence_pc + XLEN'(4);
        end
      end
      ST_DRAIN: begin
        cnt_d = cnt_q + 8'd1;
        if (hi) begin
          st_d = ST_IDLE;
        end else if (pipe_empty) begin
          st_d = ST_FLUSH;
        end else if (cnt_q + 8'd1 == DRAIN_MAX) begin
          tmo  = 1'b1;
          st_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (hi || (sel == SRC_FENCE && redir_ready)) begin
          st_d = ST_IDLE;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pend_v_d    = pend_v_q;
    pend_full_d = pend_full_q;
    pend_a_d    = pend_a_q;
    if (!redir_ready &&
        (sel == SRC_CSR || sel == SRC_EX || sel == SRC_JUMP)) begin
      pend_v_d    = 1'b1;
      pend_full_d = sel != SRC_JUMP;
      pend_a_d    = addr;
    end else if (redir_ready && sel == SRC_PEND) begin
      pend_v_d    = 1'b0;
      pend_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= ST_IDLE;
      cnt_q       <= 8'd0;
      fen_a_q     <= '0;
      pend_v_q    <= 1'b0;
      pend_full_q <= 1'b0;
      pend_a_q    <= '0;
    end else begin
      st_q        <= st_d;
      cnt_q       <= cnt_d;
      fen_a_q     <= fen_a_d;
      pend_v_q    <= pend_v_d;
      pend_full_q <= pend_full_d;
      pend_a_q    <= pend_a_d;
    end
  end

endmodule
